// File: rtl/kawiarka_pkg.sv
// Shared definitions for the coffee order controller and the brewer side.
// Holds the controller state encoding, the default cup price and the
// start/done handshake timing constants both ends of the link agree on.
package kawiarka_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] REQ   = 2'b01;
  localparam logic [1:0] GAP   = 2'b10;
  localparam logic [1:0] FAULT = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = IDLE,
    StReq   = REQ,
    StGap   = GAP,
    StFault = FAULT
  } state_e;

  // Cost of one cup in coin units.
  localparam int unsigned DefaultPrice = 4;

  // Cycles the brewer may hold off brew_done before the initiator gives up.
  localparam int unsigned DefaultTimeout = 64;

  // Cycles brew_req stays low after a completion before the next launch
  // decision; the brewer needs this to fall back to its idle state.
  localparam int unsigned BrewGapCycles = 1;

endpackage

// File: rtl/licznik_kredytu.sv
// Saturating coin credit counter.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   inc_i       - add one coin unit this cycle
//   sub_i       - deduct PRICE this cycle (ignored when credit < PRICE)
//   credit_o    - registered credit, saturates at 2^CREDIT_W-1
//   ge_price_o  - registered credit is at least PRICE
module licznik_kredytu
  import kawiarka_pkg::*;
#(
  parameter int unsigned PRICE    = DefaultPrice,
  parameter int unsigned CREDIT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc_i,
  input  logic                sub_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                ge_price_o
);

  localparam logic [CREDIT_W:0] PriceW    = (CREDIT_W + 1)'(PRICE);
  localparam logic [CREDIT_W:0] CreditMax = {1'b0, {CREDIT_W{1'b1}}};

  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W:0]   sum;

  assign ge_price_o = ({1'b0, credit_q} >= PriceW);

  // One extra bit of headroom so the coin can be added before deciding on
  // saturation; the final result is clamped, so a coin at full credit is lost.
  always_comb begin
    sum = {1'b0, credit_q} + {{CREDIT_W{1'b0}}, inc_i};
    if (sub_i && ge_price_o) begin
      sum = sum - PriceW;
    end
    if (sum > CreditMax) begin
      credit_d = CreditMax[CREDIT_W-1:0];
    end else begin
      credit_d = sum[CREDIT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_d;
    end
  end

  assign credit_o = credit_q;

endmodule

// File: rtl/zamawianie_kawy.sv
// Coffee order controller: initiator side of the brewer start/done handshake.
// Accumulates coin credit, accepts paid cup orders into a small queue and
// launches one brew at a time, holding brew_req high for the whole brew.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   coin       - one-cycle pulse, one coin unit inserted
//   order      - one-cycle pulse, cup button pressed
//   svc_clear  - service pulse, leaves the fault state
//   brew_done  - brewer completion pulse
//   brew_req   - start request to brewer (registered)
//   credit     - unspent credit (registered)
//   pending    - queued orders including the one brewing (registered)
//   busy       - brew in progress or in the post-brew gap
//   error      - sticky watchdog fault flag (registered)
module zamawianie_kawy
  import kawiarka_pkg::*;
#(
  parameter int unsigned PRICE     = DefaultPrice,
  parameter int unsigned CREDIT_W  = 4,
  parameter int unsigned MAX_QUEUE = 3,
  parameter int unsigned TIMEOUT   = DefaultTimeout,
  parameter int unsigned TO_W      = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin,
  input  logic                order,
  input  logic                svc_clear,
  input  logic                brew_done,
  output logic                brew_req,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          pending,
  output logic                busy,
  output logic                error
);

  localparam logic [1:0]      MaxQueue = 2'(MAX_QUEUE);
  localparam logic [TO_W-1:0] WdLast   = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [1:0]      pending_q, pending_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            brew_req_q, brew_req_d;
  logic            error_q, error_d;

  logic accepted;
  logic completed;
  logic ge_price;

  // Acceptance looks only at registered credit, so a same-cycle coin cannot
  // pay for the order it arrives with.
  assign accepted = order && ge_price && (pending_q < MaxQueue) && (state_q != StFault);

  licznik_kredytu #(
    .PRICE    (PRICE),
    .CREDIT_W (CREDIT_W)
  ) u_licznik_kredytu (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (coin),
    .sub_i      (accepted),
    .credit_o   (credit),
    .ge_price_o (ge_price)
  );

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    completed = 1'b0;

    case (state_q)
      StIdle: begin
        if (pending_q != 2'd0) begin
          state_d = StReq;
          wd_d    = '0;
        end
      end
      StReq: begin
        wd_d = wd_q + 1'b1;
        // Completion wins over a timeout landing in the same cycle.
        if (brew_done) begin
          completed = 1'b1;
          state_d   = StGap;
        end else if (wd_q == WdLast) begin
          state_d = StFault;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      StFault: begin
        if (svc_clear) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    case ({accepted, completed})
      2'b10:   pending_d = pending_q + 2'd1;
      2'b01:   pending_d = pending_q - 2'd1;
      default: pending_d = pending_q;
    endcase
    // A stalled brewer loses the whole queue; credit is left untouched.
    if (state_d == StFault) begin
      pending_d = 2'd0;
    end

    brew_req_d = (state_d == StReq);
    error_d    = (state_d == StFault);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pending_q  <= 2'd0;
      wd_q       <= '0;
      brew_req_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      wd_q       <= wd_d;
      brew_req_q <= brew_req_d;
      error_q    <= error_d;
    end
  end

  assign brew_req = brew_req_q;
  assign pending  = pending_q;
  assign error    = error_q;
  assign busy     = (state_q == StReq) || (state_q == StGap);

endmodule

// File: tb/tb_zamawianie_kawy.sv
// Self-checking bench for zamawianie_kawy: a cycle model built from the
// ordering rules is compared every cycle, and directed sequences pin
// hand-computed values.
module tb_zamawianie_kawy;
  import kawiarka_pkg::*;

  localparam int Price     = 4;
  localparam int CreditW   = 4;
  localparam int MaxQueue  = 3;
  localparam int Timeout   = 64;
  localparam int ToW       = 7;
  localparam int CreditMax = 15;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               coin = 1'b0;
  logic               order = 1'b0;
  logic               svc_clear = 1'b0;
  logic               brew_done = 1'b0;
  logic               brew_req;
  logic [CreditW-1:0] credit;
  logic [1:0]         pending;
  logic               busy;
  logic               error;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: credit, queue length, whether a brew is being requested, how many
  // REQ cycles have elapsed, gap cycles left, and the fault flag.
  int m_credit = 0;
  int m_queue  = 0;
  int m_waited = 0;
  int m_gap    = 0;
  bit m_req    = 1'b0;
  bit m_fault  = 1'b0;

  always #5 clk = ~clk;

  zamawianie_kawy #(
    .PRICE     (Price),
    .CREDIT_W  (CreditW),
    .MAX_QUEUE (MaxQueue),
    .TIMEOUT   (Timeout),
    .TO_W      (ToW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .coin      (coin),
    .order     (order),
    .svc_clear (svc_clear),
    .brew_done (brew_done),
    .brew_req  (brew_req),
    .credit    (credit),
    .pending   (pending),
    .busy      (busy),
    .error     (error)
  );

  task automatic cmp(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit c, input bit o, input bit s, input bit d, input bit r);
    bit acc;
    bit fin;
    int q0;
    if (r) begin
      m_credit = 0;
      m_queue  = 0;
      m_waited = 0;
      m_gap    = 0;
      m_req    = 1'b0;
      m_fault  = 1'b0;
      return;
    end
    q0  = m_queue;
    acc = o && (m_credit >= Price) && (q0 < MaxQueue) && !m_fault;
    m_credit = m_credit + int'(c) - (acc ? Price : 0);
    if (m_credit > CreditMax) m_credit = CreditMax;
    fin = 1'b0;
    if (m_fault) begin
      if (s) m_fault = 1'b0;
    end else if (m_req) begin
      if (d) begin
        m_req = 1'b0;
        m_gap = BrewGapCycles;
        fin   = 1'b1;
      end else if (m_waited == Timeout - 1) begin
        m_req   = 1'b0;
        m_fault = 1'b1;
      end else begin
        m_waited++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (q0 > 0) begin
      m_req    = 1'b1;
      m_waited = 0;
    end
    m_queue = m_fault ? 0 : q0 + int'(acc) - int'(fin);
  endtask

  // Inputs are applied 1 ns after the previous edge and held for one cycle.
  task automatic tick(input bit c, input bit o, input bit s, input bit d, input bit r);
    coin      = c;
    order     = o;
    svc_clear = s;
    brew_done = d;
    rst       = r;
    @(posedge clk);
    model_step(c, o, s, d, r);
    #1;
    coin      = 1'b0;
    order     = 1'b0;
    svc_clear = 1'b0;
    brew_done = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  task automatic coins(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 10 && !brew_req; i++) tick(0, 0, 0, 0, 0);
    cmp("wait_brew_req", int'(brew_req), 1);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_credit", int'(credit), m_credit);
      cmp("model_pending", int'(pending), m_queue);
      cmp("model_brew_req", int'(brew_req), int'(m_req));
      cmp("model_busy", int'(busy), int'(m_req || (m_gap > 0)));
      cmp("model_error", int'(error), int'(m_fault));
    end
  end

  initial begin
    // Reset state
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    chk_en = 1'b1;
    cmp("rst_credit", int'(credit), 0);
    cmp("rst_pending", int'(pending), 0);
    cmp("rst_brew_req", int'(brew_req), 0);
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_error", int'(error), 0);

    // Basic cup
    coins(4);
    cmp("basic_credit4", int'(credit), 4);
    tick(0, 1, 0, 0, 0);
    cmp("basic_credit0", int'(credit), 0);
    cmp("basic_pending1", int'(pending), 1);
    cmp("basic_req_not_yet", int'(brew_req), 0);
    idle(1);
    cmp("basic_req_rise", int'(brew_req), 1);
    cmp("basic_busy", int'(busy), 1);
    idle(3);
    tick(0, 0, 0, 1, 0);
    cmp("basic_gap_req", int'(brew_req), 0);
    cmp("basic_gap_pending", int'(pending), 0);
    cmp("basic_gap_busy", int'(busy), 1);
    idle(1);
    cmp("basic_idle_busy", int'(busy), 0);
    cmp("basic_idle_req", int'(brew_req), 0);

    // Insufficient credit
    tick(0, 0, 0, 0, 1);
    coins(3);
    tick(0, 1, 0, 0, 0);
    cmp("poor_credit", int'(credit), 3);
    cmp("poor_pending", int'(pending), 0);
    idle(5);
    cmp("poor_no_req", int'(brew_req), 0);

    // Saturation, queue full, back-to-back cups
    tick(0, 0, 0, 0, 1);
    coins(16);
    cmp("sat_credit", int'(credit), 15);
    for (int i = 0; i < 4; i++) tick(0, 1, 0, 0, 0);
    cmp("full_pending", int'(pending), 3);
    cmp("full_credit", int'(credit), 3);
    for (int k = 0; k < 3; k++) begin
      wait_req();
      tick(0, 0, 0, 1, 0);
      cmp("b2b_pending", int'(pending), 2 - k);
      cmp("b2b_gap_req", int'(brew_req), 0);
      cmp("b2b_gap_busy", int'(busy), 1);
      idle(1);
      cmp("b2b_idle_req", int'(brew_req), 0);
      cmp("b2b_idle_busy", int'(busy), 0);
      if (k < 2) begin
        idle(1);
        cmp("b2b_relaunch", int'(brew_req), 1);
      end
    end

    // Simultaneous events
    tick(0, 0, 0, 0, 1);
    coins(4);
    tick(1, 1, 0, 0, 0);
    cmp("sim_credit1", int'(credit), 1);
    cmp("sim_pending1", int'(pending), 1);
    idle(1);
    coins(3);
    cmp("sim_credit4", int'(credit), 4);
    tick(0, 1, 0, 1, 0);
    cmp("sim_pending_same", int'(pending), 1);
    cmp("sim_credit0", int'(credit), 0);
    cmp("sim_gap_req", int'(brew_req), 0);
    idle(2);
    cmp("sim_next_cup", int'(brew_req), 1);
    tick(0, 0, 0, 1, 0);
    idle(2);
    cmp("sim_drained", int'(pending), 0);

    // Watchdog
    tick(0, 0, 0, 0, 1);
    coins(4);
    tick(0, 1, 0, 0, 0);
    idle(1);
    cmp("wd_req", int'(brew_req), 1);
    idle(Timeout - 1);
    cmp("wd_still_req", int'(brew_req), 1);
    cmp("wd_no_err_yet", int'(error), 0);
    idle(1);
    cmp("wd_error", int'(error), 1);
    cmp("wd_req_low", int'(brew_req), 0);
    cmp("wd_pending0", int'(pending), 0);
    coins(4);
    cmp("wd_coins_count", int'(credit), 4);
    tick(0, 1, 0, 0, 0);
    cmp("wd_order_drop", int'(pending), 0);
    cmp("wd_credit_kept", int'(credit), 4);
    tick(0, 0, 0, 1, 0);
    cmp("wd_done_ignored", int'(pending), 0);
    tick(0, 0, 1, 0, 0);
    cmp("wd_cleared", int'(error), 0);
    idle(1);
    cmp("wd_idle_req", int'(brew_req), 0);

    // Reset mid-brew
    tick(0, 0, 0, 0, 1);
    coins(8);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    cmp("mid_pending2", int'(pending), 2);
    wait_req();
    tick(0, 0, 0, 0, 1);
    cmp("mid_req_drop", int'(brew_req), 0);
    cmp("mid_pending0", int'(pending), 0);
    cmp("mid_credit0", int'(credit), 0);
    tick(0, 0, 0, 1, 0);
    cmp("mid_done_pending", int'(pending), 0);
    cmp("mid_done_req", int'(brew_req), 0);
    cmp("mid_done_busy", int'(busy), 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zamawianie_kawy.md
Name: zamawianie_kawy

Overview:
- Initiator side of the brewer start/done handshake: an order controller for the coffee machine front panel.
- Accumulates coin credit and accepts cup orders against a fixed price.
- Queues paid orders and drives the brewer's start request, holding it high for the whole brew because the brewer aborts to idle when its start input drops.
- Waits for the brewer's completion, then launches the next queued cup. A watchdog flags a stalled brewer.

Parameters:
PRICE, 4, cost of one cup in coin units
CREDIT_W, 4, credit register width; credit saturates at 2^CREDIT_W-1
MAX_QUEUE, 3, maximum paid-but-unbrewed orders
TIMEOUT, 64, cycles allowed in REQ before fault
TO_W, 7, watchdog counter width; must hold TIMEOUT

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
coin  in  1  one-cycle pulse, one coin unit inserted
order  in  1  one-cycle pulse, cup button pressed
svc_clear  in  1  service pulse, clears fault
brew_done  in  1  brewer completion pulse
brew_req  out  1  start request to brewer, held high during brew
credit  out  CREDIT_W  current unspent credit
pending  out  2  queued orders, including the one brewing
busy  out  1  high in REQ or GAP
error  out  1  sticky fault flag

Behaviour:
- Reset, sampled on the clk edge: state=IDLE, credit=0, pending=0, brew_req=0, busy=0, error=0, watchdog=0. Reset mid-brew drops brew_req on the next edge; queued orders and credit are lost.
- States:
  - IDLE, brew_req=0
  - REQ, brew_req=1
  - GAP, brew_req=0 for exactly one cycle
  - FAULT, brew_req=0, error=1
- Order acceptance:
  - An order is accepted iff order=1, registered credit>=PRICE, pending<MAX_QUEUE and state!=FAULT. Otherwise it is silently dropped.
  - Acceptance uses the credit value before the same-cycle coin is added.
- Credit update per cycle: credit_next = credit + coin - (accepted ? PRICE : 0), saturated at 2^CREDIT_W-1. A coin at saturation is lost and credit never wraps.
- Pending update: pending_next = pending + accepted - completed. A simultaneous accept and complete leaves pending unchanged.
- IDLE -> REQ when pending>0, evaluated on the registered value. brew_req rises one cycle after the accepting edge. The watchdog clears on entry.
- REQ:
  - The watchdog increments every cycle.
  - brew_done=1 -> GAP with completed=1. brew_done has priority over the timeout in the same cycle.
  - Watchdog==TIMEOUT-1 without brew_done -> FAULT: pending forced to 0, credit kept, error=1.
- GAP -> IDLE unconditionally. This guarantees brew_req is low for at least one cycle between cups so the brewer re-enters idle. Back-to-back cups therefore give REQ, GAP, IDLE, REQ.
- FAULT -> IDLE on svc_clear, error->0. Coins still accumulate in FAULT. svc_clear outside FAULT is ignored.
- brew_done outside REQ is ignored and does not change pending.
- busy is combinational from the registered state. All other outputs are registered.

Decomposition:
- Shared package kawiarka_pkg holds:
  - state localparams: IDLE=2'b00, REQ=2'b01, GAP=2'b10, FAULT=2'b11
  - the default PRICE
  - the brew_req/brew_done handshake timing constants, which the brewer side also uses
- One natural sub-module, licznik_kredytu: saturating credit counter with inc/sub inputs, a ge_price flag, and parameters PRICE and CREDIT_W. The FSM, queue counter and watchdog stay in the top.

Test Plan:
- Basic cup: 4 coin pulses, then order. Expect credit 4->0 and pending=1; brew_req=1 from the following cycle. brew_done at cycle+5 -> brew_req=0 for one cycle, pending=0, busy=0.
- Insufficient credit: 3 coins, then order. Expect order dropped, credit=3, pending=0, brew_req never rises.
- Queue full and back-to-back: 15 coins (credit saturates at 15), 4 orders. Expect pending=3, credit=3, fourth order rejected. Three brew_done pulses -> brew_req low exactly one cycle between each, pending 3->2->1->0.
- Simultaneous events:
  - credit=4 with coin and order in the same cycle -> credit=1.
  - While brewing, accept and brew_done in the same cycle -> pending unchanged.
- Watchdog: launch a cup and withhold brew_done for 64 cycles. Expect FAULT, error=1, brew_req=0, pending=0, orders rejected, coins still counted. svc_clear -> IDLE, error=0.
- Reset mid-brew: rst during REQ with pending=2. Next edge: brew_req=0, pending=0, credit=0, brew_done afterwards ignored.
